// File: rtl/apb_uart_tx.sv
// APB-mapped 8N1 UART transmitter: TX FIFO, programmable baud divider, status and level irq.
// Latency: zero-wait-state APB (PREADY = PSEL & PENABLE); first start bit two cycles after EN/push meets an idle FSM.
// Backpressure: none on APB; a push into a full FIFO is dropped and latches the sticky OVF flag.
//
// Ports:
//   PCLK, PRESET                    clock and synchronous active-high reset
//   PADDR[3:0], PWDATA, PWRITE,
//   PENABLE, PSEL                   APB slave request (PADDR[3:2] selects CTRL/STATUS/TXDATA/BAUD_DIV)
//   PRDATA, PREADY                  APB response; PRDATA is zero outside read access phases
//   tx                              UART serial line, idle high, LSB first
//   irq                             registered level interrupt: IE & EN & FIFO empty & FSM idle
module apb_uart_tx #(
  parameter int          FIFO_DEPTH = 8,
  parameter int          CNT_W      = 4,
  parameter logic [15:0] BAUD_RST   = 16'd867
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        tx,
  output logic        irq
);

  localparam int PTR_W = CNT_W - 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic             access, wr_en, rd_en;
  logic [1:0]       reg_sel;
  logic             ctrl_en, ctrl_ie;
  logic [15:0]      baud_div;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic             push, push_ok, pop, full, empty, busy;
  state_t           state, state_nxt;
  logic [15:0]      baud_cnt, baud_nxt;
  logic [2:0]       bit_cnt, bit_nxt;
  logic [7:0]       shift, shift_nxt;
  logic             bit_end, tx_nxt, tx_q, irq_q;
  logic [31:0]      status, rdata;
  logic             unused_bits;

  assign access  = PSEL & PENABLE;
  assign PREADY  = access;
  assign wr_en   = access & PWRITE;
  assign rd_en   = access & ~PWRITE;
  assign reg_sel = PADDR[3:2];

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign busy    = (state != IDLE);
  assign push    = wr_en && (reg_sel == 2'd2);
  // Acceptance looks only at the pre-edge count, so a same-cycle pop never frees room for a push.
  assign push_ok = push && !full;

  assign unused_bits = ^{PADDR[1:0], PWDATA[31:16]};

  // Control registers and sticky overflow flag.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ctrl_en  <= 1'b0;
      ctrl_ie  <= 1'b0;
      baud_div <= BAUD_RST;
      ovf      <= 1'b0;
    end else begin
      if (wr_en && reg_sel == 2'd0) {ctrl_ie, ctrl_en} <= PWDATA[1:0];
      if (wr_en && reg_sel == 2'd3) baud_div <= PWDATA[15:0];
      if (push && !push_ok)
        ovf <= 1'b1;
      else if (wr_en && reg_sel == 2'd1 && PWDATA[3])
        ovf <= 1'b0;
    end
  end

  // FIFO bookkeeping; pointers wrap naturally since FIFO_DEPTH is a power of two.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge PCLK) begin
    if (push_ok) mem[wr_ptr] <= PWDATA[7:0];
  end

  // >= rather than == so that shrinking BAUD_DIV below the running count ends the bit
  // on the next cycle instead of letting the counter run around.
  assign bit_end = (baud_cnt >= baud_div);

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl_en && !empty) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr];
          baud_nxt  = '0;
          bit_nxt   = '0;
          state_nxt = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_nxt  = '0;
          state_nxt = DATA;
        end else begin
          baud_nxt  = baud_cnt + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_nxt  = '0;
          shift_nxt = shift >> 1;
          bit_nxt   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = STOP;
        end else begin
          baud_nxt  = baud_cnt + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_nxt  = '0;
          state_nxt = IDLE;
        end else begin
          baud_nxt  = baud_cnt + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // tx is registered from next-state values so the pin is a clean flop aligned with the FSM state.
  always_comb begin
    tx_nxt = 1'b1;
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
      irq_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shift    <= shift_nxt;
      tx_q     <= tx_nxt;
      irq_q    <= ctrl_ie & ctrl_en & empty & ~busy;
    end
  end

  assign tx  = tx_q;
  assign irq = irq_q;

  always_comb begin
    status             = '0;
    status[0]          = full;
    status[1]          = empty;
    status[2]          = busy;
    status[3]          = ovf;
    status[8 +: CNT_W] = count;
  end

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (reg_sel)
        2'd0:    rdata[1:0]  = {ctrl_ie, ctrl_en};
        2'd1:    rdata       = status;
        2'd3:    rdata[15:0] = baud_div;
        default: rdata       = '0;
      endcase
    end
  end

  assign PRDATA = rdata;

endmodule

// File: tb/tb_apb_uart_tx.sv
// Scoreboard bench for apb_uart_tx: expected read data and expected UART bytes are queued
// by the stimulus; independent monitors compare APB read data and decode frames on tx.
// Cycle-exact checks (busy window, frame spacing, irq rise) are keyed off monitor timestamps.
module tb_apb_uart_tx;

  logic        PCLK, PRESET;
  logic [3:0]  PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PENABLE, PSEL;
  logic [31:0] PRDATA;
  logic        PREADY, tx, irq;

  apb_uart_tx #(.FIFO_DEPTH(8), .CNT_W(4), .BAUD_RST(16'd867)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PENABLE(PENABLE), .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY), .tx(tx), .irq(irq)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] rd_exp_q[$];
  string       rd_name_q[$];
  logic [7:0]  rx_q[$];
  int          starts[$];
  int          frames_seen = 0;
  int          bit_len = 868;
  bit          rx_ignore = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // APB read data monitor.
  always @(negedge PCLK) begin
    if (PSEL && PENABLE && !PWRITE) begin
      if (rd_exp_q.size() == 0) begin
        n_total++;
        $display("FAIL rd_unexpected: PRDATA 0x%08h with no expectation queued", PRDATA);
      end else begin
        chk(rd_name_q.pop_front(), PRDATA, rd_exp_q.pop_front());
      end
    end
  end

  // UART receive monitor: checks every cycle of a frame against the ideal waveform.
  initial begin : rx_mon
    logic [7:0] eb, got;
    logic       expb;
    int         k, l, bad, b;
    bit         ign;
    forever begin
      @(negedge PCLK);
      if (PRESET === 1'b0 && tx === 1'b0) begin
        k   = cyc;
        l   = bit_len;
        ign = rx_ignore;
        frames_seen++;
        starts.push_back(k);
        eb  = 8'h00;
        if (!ign) begin
          if (rx_q.size() == 0) begin
            n_total++;
            $display("FAIL rx_unexpected_frame at cycle %0d", k);
            ign = 1'b1;
          end else begin
            eb = rx_q.pop_front();
          end
        end
        bad = 0;
        got = 8'h00;
        for (int j = 0; j < 10 * l; j++) begin
          if (j > 0) @(negedge PCLK);
          b = j / l;
          if (b == 0)      expb = 1'b0;
          else if (b == 9) expb = 1'b1;
          else             expb = eb[b-1];
          if (tx !== expb) bad++;
          if (b >= 1 && b <= 8 && (j % l) == l / 2) got[b-1] = tx;
        end
        if (!ign) begin
          chk("rx_byte", {24'h0, got}, {24'h0, eb});
          chk("rx_wave_errors", bad, 0);
        end
      end
    end
  end

  // All tasks are entered 1 time unit after a rising edge and return likewise.
  task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
    PADDR = a; PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_rd_core(input logic [3:0] a, input int n);
    PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    repeat (n) begin @(posedge PCLK); #1; end
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] a, input logic [31:0] e, input string name);
    rd_exp_q.push_back(e);
    rd_name_q.push_back(name);
    apb_rd_core(a, 1);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin @(posedge PCLK); #1; end
  endtask

  task automatic wait_frames(input int target, input string name);
    int t;
    t = 0;
    while (frames_seen < target && t < 2000) begin @(posedge PCLK); #1; t++; end
    chk(name, frames_seen, target);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int prev, k, k1, k2;
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 4'h0; PWDATA = '0;
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_irq", irq, 0);
    chk("rst_pready", PREADY, 0);
    chk("rst_prdata", PRDATA, 0);
    PRESET = 1'b0;
    @(posedge PCLK); #1;
    apb_read(4'h4, 32'h0000_0002, "rst_status");
    apb_read(4'hC, 32'h0000_0363, "rst_baud");
    apb_read(4'h0, 32'h0000_0000, "rst_ctrl");

    // 0xA5 at 4 cycles per bit; BUSY window k..k+39.
    apb_write(4'hC, 32'd3); bit_len = 4;
    rx_q.push_back(8'hA5);
    apb_write(4'h8, 32'h0000_00A5);
    apb_read(4'h4, 32'h0000_0100, "status_one_queued");
    prev = frames_seen;
    apb_write(4'h0, 32'h1);
    wait_frames(prev + 1, "a5_frame_seen");
    k = starts[prev];
    wait_cyc(k + 38);
    rd_exp_q.push_back(32'h0000_0006); rd_name_q.push_back("busy_last_stop_cycle");
    rd_exp_q.push_back(32'h0000_0002); rd_name_q.push_back("idle_after_40_cycles");
    apb_rd_core(4'h4, 2);
    chk("irq_ie_off", irq, 0);

    // Overflow: EN=0, nine pushes into an 8-deep FIFO.
    apb_write(4'h0, 32'h0);
    for (int i = 0; i < 9; i++) apb_write(4'h8, 32'h10 + i);
    apb_read(4'h4, 32'h0000_0809, "status_full_ovf");
    apb_write(4'h4, 32'h8);
    apb_read(4'h4, 32'h0000_0801, "status_ovf_cleared");

    // Drain at 1 cycle per bit; the rejected 9th byte must not appear.
    apb_write(4'hC, 32'd0); bit_len = 1;
    for (int i = 0; i < 8; i++) rx_q.push_back(8'h10 + 8'(i));
    prev = frames_seen;
    apb_write(4'h0, 32'h1);
    wait_frames(prev + 8, "drain_frames_seen");
    repeat (15) @(posedge PCLK);
    #1;
    apb_read(4'h4, 32'h0000_0002, "status_drained");

    // Two back-to-back frames with IE: one idle cycle between, irq one cycle after the stop bit.
    apb_write(4'h0, 32'h0);
    rx_q.push_back(8'h01); rx_q.push_back(8'h02);
    apb_write(4'h8, 32'h01);
    apb_write(4'h8, 32'h02);
    chk("irq_before_enable", irq, 0);
    prev = frames_seen;
    apb_write(4'h0, 32'h3);
    wait_frames(prev + 2, "pair_frames_seen");
    k1 = starts[prev];
    k2 = starts[prev + 1];
    chk("frame_spacing", k2 - k1, 11);
    for (int t = 0; t < 100; t++) begin
      @(negedge PCLK);
      if (irq === 1'b1) break;
    end
    chk("irq_rise_cycle", cyc, k2 + 11);
    @(posedge PCLK); #1;

    // Clearing EN mid-DATA completes the frame and stops further pops.
    apb_write(4'h0, 32'h0);
    @(posedge PCLK); #1;
    chk("irq_en_cleared", irq, 0);
    apb_write(4'hC, 32'd3); bit_len = 4;
    rx_q.push_back(8'h3C);
    apb_write(4'h8, 32'h3C);
    apb_write(4'h8, 32'hC3);
    prev = frames_seen;
    apb_write(4'h0, 32'h1);
    wait_frames(prev + 1, "enoff_frame_seen");
    k = starts[prev];
    wait_cyc(k + 10);
    apb_write(4'h0, 32'h0);
    wait_cyc(k + 70);
    chk("enoff_no_new_frame", frames_seen, prev + 1);
    chk("enoff_tx_idle", tx, 1);
    apb_read(4'h4, 32'h0000_0100, "status_enoff");

    // Reset in the middle of DATA (bit 2 of 0xC3 is 0) with one byte still queued.
    apb_write(4'h8, 32'h77);
    rx_ignore = 1'b1;
    prev = frames_seen;
    apb_write(4'h0, 32'h1);
    wait_frames(prev + 1, "abort_frame_seen");
    k = starts[prev];
    wait_cyc(k + 13);
    chk("tx_before_reset", tx, 0);
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    chk("tx_after_reset", tx, 1);
    chk("irq_after_reset", irq, 0);
    PRESET = 1'b0;
    apb_read(4'h4, 32'h0000_0002, "status_after_reset");
    apb_read(4'hC, 32'h0000_0363, "baud_after_reset");
    apb_read(4'h0, 32'h0000_0000, "ctrl_after_reset");
    wait_cyc(k + 45);
    rx_ignore = 1'b0;
    bit_len = 868;

    // SETUP-only cycles must not push.
    PADDR = 4'h8; PWDATA = 32'h55; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    repeat (3) begin
      @(negedge PCLK);
      chk("setup_pready", PREADY, 0);
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PWRITE = 1'b0;
    apb_read(4'h4, 32'h0000_0002, "status_setup_only");

    // Register masking and TXDATA read-as-zero.
    apb_write(4'h0, 32'hFFFF_FFFF);
    apb_read(4'h0, 32'h0000_0003, "ctrl_mask");
    apb_write(4'hC, 32'hFFFF_ABCD);
    apb_read(4'hC, 32'h0000_ABCD, "baud_mask");
    apb_read(4'h8, 32'h0000_0000, "txdata_reads_zero");
    chk("irq_idle_enabled", irq, 1);
    chk("tx_idle_end", tx, 1);

    repeat (5) @(posedge PCLK);
    #1;
    chk("rd_queue_drained", rd_exp_q.size(), 0);
    chk("rx_queue_drained", rx_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/apb_uart_tx.md
Name: apb_uart_tx

Overview:
- APB slave peripheral that sits downstream of the APB master/decoder, on one PSELx slot in the 0x1000_xxxx peripheral window.
- Provides a register-mapped UART transmitter (8N1, LSB first) with a TX FIFO, a programmable baud divider, status flags and a level interrupt.
- Software pushes bytes through APB; the block serialises them onto the `tx` pin.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..64.
- CNT_W, 4, FIFO count width; must equal log2(FIFO_DEPTH)+1.
- BAUD_RST, 16'd867, reset value of BAUD_DIV (100 MHz / 115200 - 1).

Ports:
- PCLK  in  1  system clock; all logic on rising edge.
- PRESET  in  1  reset, synchronous, active-high.
- PADDR  in  4  byte address within the slot; [3:2] selects the register, [1:0] ignored.
- PWDATA  in  32  write data.
- PWRITE  in  1  1 = write, 0 = read.
- PENABLE  in  1  APB access phase.
- PSEL  in  1  slot select from the decoder.
- PRDATA  out  32  read data.
- PREADY  out  1  transfer complete.
- tx  out  1  UART serial output; idle high.
- irq  out  1  TX-done interrupt, level.

Behaviour:
- Reset (synchronous, PRESET=1 at a PCLK edge):
  - CTRL=0, BAUD_DIV=BAUD_RST, FIFO empty (wr_ptr=rd_ptr=count=0), OVF=0, FSM=IDLE, baud counter=0, bit counter=0.
  - Outputs: tx=1, irq=0, PREADY=0, PRDATA=0.
  - Reset mid-frame aborts the frame: tx returns high on the next edge and FIFO contents are lost.
- APB timing, zero wait states:
  - PREADY = PSEL & PENABLE (combinational).
  - PRDATA is combinational from the registers while PSEL & PENABLE & !PWRITE; otherwise 0.
  - Register side effects occur only on the edge where PSEL & PENABLE & PREADY. SETUP phase (PENABLE=0) has no effect.
- Register map:
  - 0x0 CTRL (RW): bit0 EN (transmit enable), bit1 IE (interrupt enable); other bits read 0.
  - 0x4 STATUS (RO, except OVF): bit0 FULL, bit1 EMPTY, bit2 BUSY, bit3 OVF (sticky; writing 1 to bit3 clears it), bits[8+CNT_W-1:8] FIFO count.
  - 0x8 TXDATA (WO): write pushes PWDATA[7:0] into the FIFO; reads return 0.
  - 0xC BAUD_DIV (RW): bits[15:0]. Bit period = BAUD_DIV+1 PCLK cycles; BAUD_DIV=0 gives 1 cycle per bit.
- FIFO rules:
  - A push is accepted iff count < FIFO_DEPTH, evaluated on the pre-edge count, regardless of a same-cycle pop.
  - A rejected push sets OVF and leaves the FIFO unchanged.
  - Simultaneous accepted push and pop leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- TX FSM (states IDLE, START, DATA, STOP):
  - IDLE: tx=1. If EN=1 and count>0, pop the head into the shift register, clear the baud and bit counters, go to START.
  - START: tx=0 for BAUD_DIV+1 cycles, then go to DATA.
  - DATA: tx=shift[0]. At the end of each bit period shift right and increment the bit counter; after bit 7's period go to STOP.
  - STOP: tx=1 for BAUD_DIV+1 cycles, then go to IDLE.
  - Back-to-back frames have exactly one IDLE cycle between stop and the next start bit.
  - The baud counter counts 0..BAUD_DIV and resets to 0 on a state change.
  - A BAUD_DIV write during a frame takes effect at the next counter compare, with no glitch on tx.
  - Clearing EN mid-frame completes the current frame; no further pops occur.
- Derived signals:
  - BUSY = (FSM != IDLE).
  - irq = IE & EN & EMPTY & !BUSY, registered (asserts one cycle after the condition holds).

Test Plan:
- Reset then read 0x4 -> PRDATA=0x0000_0002 (EMPTY=1), tx=1, irq=0; read 0xC -> 0x0000_0363.
- BAUD_DIV=3, EN=1, push 0xA5 -> start bit 0 lasting 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then stop 1 for 4 cycles; BUSY=1 for exactly 40 cycles.
- EN=0, push 9 bytes with FIFO_DEPTH=8 -> STATUS=0x0000_0809 (count 8, FULL, OVF); write 0x8 to 0x4 -> OVF clears and reads 0x0000_0801.
- BAUD_DIV=0, IE=1, EN=1, push 0x01 and 0x02 -> two frames of 10 cycles each separated by one idle cycle; irq=1 one cycle after the second stop bit ends.
- Mid-DATA of frame 1 (two bytes queued) write CTRL=0 -> frame 1 completes, tx stays 1, STATUS count=1, BUSY=0.
- Assert PRESET during the DATA state -> tx=1 and STATUS=0x0000_0002 after the next edge; APB SETUP-only cycles (PENABLE=0) cause no push.
